// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer for the dual-fetch front end.
//
// Ports:
//   CLK, reset              clock; synchronous active-high reset
//   pc1, pc2                fetch lookup PCs, sampled every cycle
//   update_btb, ex_pc,      write request from execute: PC, resolved target and
//   actual_target_address,  branch type (at most one type bit set)
//   ex_is_branch/call/ret
//   inv_valid, inv_pc       invalidate the entry holding inv_pc
//   btb_hit1/2              registered hit, one cycle after the PC is sampled
//   pred_target1/2          registered target of the hitting way, 0 on miss
//   is_branch1/2, is_call1/2, is_ret1/2
//                           registered type bits, qualified by hit
//
// Handshake: there is none. Every input is sampled on every clock edge and
// every output is valid in every cycle; there are no stalls and no ready signals.
//
// All lookups, updates and invalidates of one cycle are evaluated against the
// pre-edge contents (read-before-write). The tree pseudo-LRU is touched by the
// port-1 hit, then the port-2 hit, then the update, so the update wins.
module btb_assoc #(
    parameter int XLEN      = 32,
    parameter int SETS_LOG2 = 5,
    parameter int WAYS      = 2,
    parameter int TAG_SIZE  = XLEN - SETS_LOG2 - 2
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [XLEN-1:0] pc1,
    input  logic [XLEN-1:0] pc2,
    input  logic            update_btb,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] actual_target_address,
    input  logic            ex_is_branch,
    input  logic            ex_is_call,
    input  logic            ex_is_ret,
    input  logic            inv_valid,
    input  logic [XLEN-1:0] inv_pc,
    output logic            btb_hit1,
    output logic            btb_hit2,
    output logic [XLEN-1:0] pred_target1,
    output logic [XLEN-1:0] pred_target2,
    output logic            is_branch1,
    output logic            is_branch2,
    output logic            is_call1,
    output logic            is_call2,
    output logic            is_ret1,
    output logic            is_ret2
);

    localparam int SETS   = 1 << SETS_LOG2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int LVLS   = $clog2(WAYS);

    typedef logic [SETS_LOG2-1:0] idx_t;
    typedef logic [TAG_SIZE-1:0]  tag_t;
    typedef logic [WAY_W-1:0]     way_t;
    typedef logic [PLRU_W-1:0]    plru_t;
    // type field packed as {is_branch, is_call, is_ret}
    typedef logic [2:0]           btype_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WAYS-1:0] valid_q  [SETS];
    logic [WAYS-1:0] valid_d  [SETS];
    tag_t            tag_q    [SETS][WAYS];
    tag_t            tag_d    [SETS][WAYS];
    logic [XLEN-1:0] target_q [SETS][WAYS];
    logic [XLEN-1:0] target_d [SETS][WAYS];
    btype_t          btype_q  [SETS][WAYS];
    btype_t          btype_d  [SETS][WAYS];
    plru_t           plru_q   [SETS];
    plru_t           plru_d   [SETS];

    logic            hit1_q,    hit1_d,    hit2_q,    hit2_d;
    logic [XLEN-1:0] target1_q, target1_d, target2_q, target2_d;
    btype_t          btype1_q,  btype1_d,  btype2_q,  btype2_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic idx_t idx_of(input logic [XLEN-1:0] pc);
        return pc[SETS_LOG2+1:2];
    endfunction

    function automatic tag_t tag_of(input logic [XLEN-1:0] pc);
        return pc[XLEN-1:SETS_LOG2+2];
    endfunction

    // Lowest set bit; 0 when the vector is empty (callers qualify with |v).
    function automatic way_t first_one(input logic [WAYS-1:0] v);
        way_t r;
        r = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v[w]) r = way_t'(w);
        end
        return r;
    endfunction

    // Tree nodes are heap-numbered from 1 (stored at bit node-1).
    // A node bit of 0 means the victim lies in the lower-index subtree.
    function automatic way_t plru_victim(input plru_t bits);
        int node;
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            node = node * 2 + int'(bits[node-1]);
        end
        return way_t'(node - WAYS);
    endfunction

    // Point every node on the path to way w away from it.
    function automatic plru_t plru_touch(input plru_t bits, input way_t w);
        plru_t r;
        int    node;
        logic  dir;
        r    = bits;
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            dir         = w[LVLS-1-l];
            r[node-1]   = ~dir;
            node        = node * 2 + int'(dir);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Lookups (pre-edge contents)
    // ------------------------------------------------------------------
    idx_t            idx1, idx2, upd_idx, inv_idx;
    tag_t            tag1, tag2, upd_tag, inv_tag;
    logic [WAYS-1:0] match1, match2, upd_match, inv_match;
    way_t            way1, way2, upd_way, inv_way;
    logic            hit1, hit2;

    always_comb begin
        idx1    = idx_of(pc1);
        idx2    = idx_of(pc2);
        upd_idx = idx_of(ex_pc);
        inv_idx = idx_of(inv_pc);
        tag1    = tag_of(pc1);
        tag2    = tag_of(pc2);
        upd_tag = tag_of(ex_pc);
        inv_tag = tag_of(inv_pc);
        for (int w = 0; w < WAYS; w++) begin
            match1[w]    = valid_q[idx1][w]    && (tag_q[idx1][w]    == tag1);
            match2[w]    = valid_q[idx2][w]    && (tag_q[idx2][w]    == tag2);
            upd_match[w] = valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag);
            inv_match[w] = valid_q[inv_idx][w] && (tag_q[inv_idx][w] == inv_tag);
        end
        hit1    = |match1;
        hit2    = |match2;
        way1    = first_one(match1);
        way2    = first_one(match2);
        inv_way = first_one(inv_match);

        // Update way: resident entry, else lowest free way, else PLRU victim.
        if (|upd_match) begin
            upd_way = first_one(upd_match);
        end else if (!(&valid_q[upd_idx])) begin
            upd_way = first_one(~valid_q[upd_idx]);
        end else begin
            upd_way = plru_victim(plru_q[upd_idx]);
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        btype_d  = btype_q;
        plru_d   = plru_q;

        // Invalidate first so a same-entry update re-validates it.
        if (inv_valid && (|inv_match)) begin
            valid_d[inv_idx][inv_way] = 1'b0;
        end
        if (update_btb) begin
            valid_d[upd_idx][upd_way]  = 1'b1;
            tag_d[upd_idx][upd_way]    = upd_tag;
            target_d[upd_idx][upd_way] = actual_target_address;
            btype_d[upd_idx][upd_way]  = {ex_is_branch, ex_is_call, ex_is_ret};
        end

        // Chained so later touches override earlier ones on shared nodes.
        if (hit1) plru_d[idx1] = plru_touch(plru_d[idx1], way1);
        if (hit2) plru_d[idx2] = plru_touch(plru_d[idx2], way2);
        if (update_btb) plru_d[upd_idx] = plru_touch(plru_d[upd_idx], upd_way);

        hit1_d    = hit1;
        hit2_d    = hit2;
        target1_d = hit1 ? target_q[idx1][way1] : '0;
        target2_d = hit2 ? target_q[idx2][way2] : '0;
        btype1_d  = hit1 ? btype_q[idx1][way1]  : '0;
        btype2_d  = hit2 ? btype_q[idx2][way2]  : '0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
            target1_q <= '0;
            target2_q <= '0;
            btype1_q  <= '0;
            btype2_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            plru_q    <= plru_d;
            hit1_q    <= hit1_d;
            hit2_q    <= hit2_d;
            target1_q <= target1_d;
            target2_q <= target2_d;
            btype1_q  <= btype1_d;
            btype2_q  <= btype2_d;
        end
    end

    // Payload needs no reset: it is never visible while its valid bit is 0.
    always_ff @(posedge CLK) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        btype_q  <= btype_d;
    end

    assign btb_hit1     = hit1_q;
    assign btb_hit2     = hit2_q;
    assign pred_target1 = target1_q;
    assign pred_target2 = target2_q;
    assign is_branch1   = btype1_q[2];
    assign is_call1     = btype1_q[1];
    assign is_ret1      = btype1_q[0];
    assign is_branch2   = btype2_q[2];
    assign is_call2     = btype2_q[1];
    assign is_ret2      = btype2_q[0];

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
Parametrised set-associative branch target buffer for the dual-fetch front end. It serves two PC lookups per cycle with registered results and takes one update per cycle from execute. It also accepts one invalidate per cycle for stale entries. Tree pseudo-LRU replacement and a 3-way branch-type field (branch/call/ret) feed the RAS and direction predictor.

Parameters:
XLEN, 32, PC/target width
SETS_LOG2, 5, log2 number of sets; index = pc[SETS_LOG2+1:2]
WAYS, 2, associativity; power of two, 1..8
TAG_SIZE, XLEN-SETS_LOG2-2, tag = pc[XLEN-1:SETS_LOG2+2]

Ports:
CLK  in  1  clock
reset  in  1  synchronous, active-high
pc1, pc2  in  XLEN  fetch lookup PCs, sampled every cycle
update_btb  in  1  write request from execute
ex_pc  in  XLEN  PC of resolved control instruction
actual_target_address  in  XLEN  resolved target
ex_is_branch, ex_is_call, ex_is_ret  in  1 each  type of resolved instruction (at most one set)
inv_valid  in  1  invalidate request
inv_pc  in  XLEN  PC whose entry is removed
btb_hit1, btb_hit2  out  1  registered hit
pred_target1, pred_target2  out  XLEN  registered target of hitting way, 0 on miss
is_branch1/2, is_call1/2, is_ret1/2  out  1 each  registered type, qualified by hit

Behaviour:
- Storage per way per set: valid, tag, target, is_branch, is_call, is_ret. Per set: WAYS-1 tree-PLRU bits.
- Reset cycle: all valid bits 0, all PLRU bits 0, every output 0. update/inv/lookups that cycle are ignored. Reset may arrive at any cycle. Contents are lost and the first post-reset lookup misses.
- Lookup latency: pcN sampled at edge t, result visible after edge t (one cycle), for both ports independently.
- Hit = valid && tag match in any way of the indexed set. Multiple matching ways in one set is illegal: the bench asserts it never occurs.
- Outputs on miss: hit, target and types all 0. Type outputs are never asserted without hit.
- Read-before-write: a lookup in the same cycle as an update/invalidate to the same set sees the pre-edge contents.
- Update way selection, in priority order:
  - a valid way with matching tag (overwrite in place);
  - else the lowest-index invalid way;
  - else the PLRU victim.
- An update writes tag, target, types, and valid=1.
- Invalidate: clears valid of the way matching inv_pc's tag. No match is a no-op. PLRU is unchanged.
- Same-cycle update and invalidate of the same index and tag: the update wins and the entry stays valid. Different entries: both take effect.
- PLRU touch (point tree away from the way), applied at the edge after evaluation, in this order:
  - port-1 hit way;
  - port-2 hit way;
  - update way (last, wins on conflict).
- WAYS=1: no PLRU state; the update always writes way 0.
- No stalls, no backpressure, no ready outputs.

Test Plan:
Config SETS_LOG2=5, WAYS=2; PCs 0x1000, 0x1080, 0x1100 all map to set 0.
1. Reset, then pc1=0x1000 -> next cycle btb_hit1=0, pred_target1=0, all type bits 0.
2. Update ex_pc=0x1000, target 0x2000, ex_is_branch=1; next cycle pc1=0x1000 -> btb_hit1=1, pred_target1=0x2000, is_branch1=1, is_call1=is_ret1=0.
3. Fill 0x1000->0x2000 (way0) and 0x1080->0x3000 (call, way1). Look up pc1=0x1000, then update 0x1100->0x4000 -> 0x1080 evicted. pc1=0x1080 misses; pc2=0x1000 hits with 0x2000.
4. With 0x1000 and 0x1080 resident, update 0x1000->0x5000 -> in-place overwrite. Both still hit; pred_target for 0x1000 is 0x5000.
5. Empty BTB, same cycle update 0x1000->0x2000 and pc1=0x1000 -> btb_hit1=0 that result. Repeat pc1 next cycle -> hit, 0x2000.
6. Resident 0x1000 (way0) and 0x1080 (way1, ret): inv_pc=0x1080 -> pc1=0x1080 misses. Update 0x1100 -> lands in way1 and 0x1000 still hits. Also drive update and invalidate of 0x1000 in the same cycle -> 0x1000 still hits.
